ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (64x8 default) between two requesters, A and B.
//  Each requester issues a read or write through a req/gnt handshake. Reads return data one cycle after acceptance.
//  Sits between the two client blocks and the RAM instance. Contention is resolved round-robin, with a burst cap per owner.
// PARAMETERS
//  ADDR_SIZE   6   address width
//  DATA_BITS   8   data width
//  NO_OF_ADDR  64  memory depth; addresses >= NO_OF_ADDR pass through unchecked
//  MAX_BURST   4   max consecutive accepted beats for one owner while the other requests (>=1)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_a      in   1          A requests an access this cycle
//  we_a       in   1          A: 1=write, 0=read
//  addr_a     in   ADDR_SIZE  A address
//  wdata_a    in   DATA_BITS  A write data
//  gnt_a      out  1          A access accepted this cycle (combinational)
//  rvalid_a   out  1          rdata_a valid (1 cycle after an accepted A read)
//  rdata_a    out  DATA_BITS  A read data
//  req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b   same as the A ports, for B
//  mem_en     out  1          RAM access strobe
//  mem_we     out  1          RAM write enable
//  mem_addr   out  ADDR_SIZE  RAM address
//  mem_wdata  out  DATA_BITS  RAM write data
//  mem_rdata  in   DATA_BITS  RAM read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Transfer occurs when req_x & gnt_x. Requester holds req/we/addr/wdata stable until granted.
//  - gnt_a & gnt_b are never both 1. A grant is only given to a requesting port.
//  - mem_en = gnt_a|gnt_b. mem_we/addr/wdata are muxed from the winner. All are 0 when idle.
//  - rdata_a = rdata_b = mem_rdata. Each is meaningful only while its rvalid is 1.
//  - rvalid_x is registered: 1 exactly in the cycle after an accepted read by x, else 0.
//  - FSM states: IDLE, OWN_A, OWN_B. Registers: beat_cnt (0..MAX_BURST, saturating) and last (last winner).
//  - Winner W each cycle:
//      no req -> none
//      one req -> that port
//      both req, state OWN_x and beat_cnt < MAX_BURST -> x
//      both req otherwise -> the port != last
//  - Next state:
//      none -> IDLE, beat_cnt=0
//      W == current owner -> stay, beat_cnt+1 (saturating)
//      W != current owner -> OWN_W, beat_cnt=1
//    last <= W whenever W exists.
//  - Latency: command reaches RAM in the accept cycle. Read data is 1 cycle later. No bubbles between grants.
//  - Owner dropping req hands over in the same cycle if the other port is requesting.
//  - Reset (async, any time): state=IDLE, beat_cnt=0, last=B (so A wins first contention), rvalid_a=rvalid_b=0.
//    An in-flight read is dropped. gnt_*/mem_* then follow the combinational rules with state IDLE.
// CONFIGURATION
//  ARB_FIXED_PRIORITY_EN defined: on contention A always wins. MAX_BURST and last are ignored. B is served only when req_a=0.
//  Undefined (default): round-robin with MAX_BURST cap, as above.
// STRUCTURE
//  Package ram_arb_pkg: state enum {IDLE, OWN_A, OWN_B}, port id encoding (PORT_A=0, PORT_B=1), beat counter width function.
//  Sub-module ram_arb_fsm: winner selection, state, beat_cnt and last. Outputs gnt_a/gnt_b.
//  The top level holds the mem_* mux and the rvalid pipeline.
// TESTING
//  1. Only A: write 8'h5A to addr 3, then read addr 3 -> gnt_a=1 both cycles; rvalid_a=1 the cycle after the read with rdata_a=8'h5A; B outputs stay 0.
//  2. A and B both request continuously from reset, MAX_BURST=4 -> grant sequence A,A,A,A,B,B,B,B,A... Never both granted.
//  3. Same simultaneous first request -> A granted first (last=B at reset). B granted in the cycle A drops req.
//  4. Assert rst_n=0 the cycle after an accepted B read -> rvalid_b stays 0, state IDLE. Next contention goes to A.
//  5. With ARB_FIXED_PRIORITY_EN, both request for 10 cycles -> gnt_a=1 all 10, gnt_b=0. gnt_b=1 the cycle req_a falls.
//  6. B write to addr 63 with A idle -> mem_en=1, mem_we=1, mem_addr=6'd63, mem_wdata=wdata_b, rvalid_b=0 next cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter.
// Fixed-priority build selected with ARB_FIXED_PRIORITY_EN (see ram_arb_fsm).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwnA,
    StOwnB
  } arb_state_e;

  localparam logic PortA = 1'b0;
  localparam logic PortB = 1'b1;

  // Enough bits to hold 0..max_burst inclusive.
  function automatic int unsigned beat_cnt_width(input int unsigned max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_arb_fsm.sv
// Winner selection, owner state, burst counter and last-winner tracking.
// ARB_FIXED_PRIORITY_EN defined: A always wins contention; otherwise round-robin with burst cap.
module ram_arb_fsm
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  localparam int unsigned CntW = beat_cnt_width(MAX_BURST);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  arb_state_e state_q, state_d, own_state;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic last_q, last_d;
  logic win_vld, win_port;

  always_comb begin
    win_vld  = req_a_i | req_b_i;
    win_port = PortA;
    if (req_a_i && req_b_i) begin
`ifdef ARB_FIXED_PRIORITY_EN
      win_port = PortA;
`else
      if (state_q == StOwnA && beat_cnt_q < MaxCnt) begin
        win_port = PortA;
      end else if (state_q == StOwnB && beat_cnt_q < MaxCnt) begin
        win_port = PortB;
      end else begin
        win_port = ~last_q;
      end
`endif
    end else if (req_b_i) begin
      win_port = PortB;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = last_q;
    own_state  = (win_port == PortA) ? StOwnA : StOwnB;
    if (!win_vld) begin
      state_d    = StIdle;
      beat_cnt_d = '0;
    end else begin
      last_d = win_port;
      if (own_state == state_q) begin
        if (beat_cnt_q < MaxCnt) beat_cnt_d = beat_cnt_q + 1'b1;
      end else begin
        state_d    = own_state;
        beat_cnt_d = CntW'(1);
      end
    end
  end

  always_comb begin
    gnt_a_o = win_vld & (win_port == PortA);
    gnt_b_o = win_vld & (win_port == PortB);
  end

  // last resets to B so that A wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      last_q     <= PortB;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B; holds the mem_* mux and
// rvalid pipeline. Build with ARB_FIXED_PRIORITY_EN for fixed A-over-B priority.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 6,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned NO_OF_ADDR = 64,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_a,
  input  logic                 we_a,
  input  logic [ADDR_SIZE-1:0] addr_a,
  input  logic [DATA_BITS-1:0] wdata_a,
  output logic                 gnt_a,
  output logic                 rvalid_a,
  output logic [DATA_BITS-1:0] rdata_a,
  input  logic                 req_b,
  input  logic                 we_b,
  input  logic [ADDR_SIZE-1:0] addr_b,
  input  logic [DATA_BITS-1:0] wdata_b,
  output logic                 gnt_b,
  output logic                 rvalid_b,
  output logic [DATA_BITS-1:0] rdata_b,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  // Addresses are not range-checked against NO_OF_ADDR; only the parameters are sanity-checked.
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end
  if (NO_OF_ADDR > (64'd1 << ADDR_SIZE)) begin : g_bad_depth
    $error("NO_OF_ADDR exceeds the address space");
  end

  logic rvalid_a_q, rvalid_a_d;
  logic rvalid_b_q, rvalid_b_d;

  ram_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_a_i(req_a),
    .req_b_i(req_b),
    .gnt_a_o(gnt_a),
    .gnt_b_o(gnt_b)
  );

  always_comb begin
    mem_en    = gnt_a | gnt_b;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  always_comb begin
    rvalid_a_d = gnt_a & ~we_a;
    rvalid_b_d = gnt_b & ~we_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = mem_rdata;
  assign rdata_b  = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes per-cycle expectations, a monitor
// pops and compares on the falling edge. Honours ARB_FIXED_PRIORITY_EN for expected grants.
module tb_ram_port_arbiter;

`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic       clk, rst_n;
  logic       req_a, we_a, gnt_a, rvalid_a;
  logic [5:0] addr_a;
  logic [7:0] wdata_a, rdata_a;
  logic       req_b, we_b, gnt_b, rvalid_b;
  logic [5:0] addr_b;
  logic [7:0] wdata_b, rdata_b;
  logic       mem_en, mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] ram [64];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       ga, gb, en, we;
    logic [5:0] addr;
    logic [7:0] wd;
    logic       rva, rvb;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];

  ram_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .we_a     (we_a),
    .addr_a   (addr_a),
    .wdata_a  (wdata_a),
    .gnt_a    (gnt_a),
    .rvalid_a (rvalid_a),
    .rdata_a  (rdata_a),
    .req_b    (req_b),
    .we_b     (we_b),
    .addr_b   (addr_b),
    .wdata_b  (wdata_b),
    .gnt_b    (gnt_b),
    .rvalid_b (rvalid_b),
    .rdata_b  (rdata_b),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous RAM.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("gnt", {30'd0, gnt_a, gnt_b}, {30'd0, e.ga, e.gb});
      check("both_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
      check("mem_en", {31'd0, mem_en}, {31'd0, e.en});
      check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
      check("mem_addr", {26'd0, mem_addr}, {26'd0, e.addr});
      check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wd});
      check("rvalid", {30'd0, rvalid_a, rvalid_b}, {30'd0, e.rva, e.rvb});
      if (e.rva) check("rdata_a", {24'd0, rdata_a}, {24'd0, e.rd});
      if (e.rvb) check("rdata_b", {24'd0, rdata_b}, {24'd0, e.rd});
    end
  end

  task automatic cyc(input logic ra, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                     input logic rb, input logic wb, input logic [5:0] ab, input logic [7:0] db,
                     input logic ega, input logic egb, input logic erva, input logic ervb,
                     input logic [7:0] erd);
    exp_t e;
    @(posedge clk);
    #1;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    e.ga   = ega;
    e.gb   = egb;
    e.en   = ega | egb;
    e.we   = ega ? wa : (egb ? wb : 1'b0);
    e.addr = ega ? aa : (egb ? ab : 6'd0);
    e.wd   = ega ? da : (egb ? db : 8'd0);
    e.rva  = erva;
    e.rvb  = ervb;
    e.rd   = erd;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic erva, input logic ervb, input logic [7:0] erd);
    cyc(0, 0, 6'd0, 8'd0, 0, 0, 6'd0, 8'd0, 0, 0, erva, ervb, erd);
  endtask

  // Assert reset just after the falling edge so the next rising edge sees it held.
  task automatic do_reset;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    idle(0, 0, 8'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
    req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
    do_reset();

    // A alone: write then read back.
    cyc(1, 1, 6'd3, 8'h5A, 0, 0, 6'd0, 8'd0, 1, 0, 0, 0, 8'd0);
    cyc(1, 0, 6'd3, 8'h00, 0, 0, 6'd0, 8'd0, 1, 0, 0, 0, 8'd0);
    idle(1, 0, 8'h5A);

    // last was A; reset must make A win the next contention.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic eb;
      eb = !Fixed && (i >= 4) && (i < 8);
      cyc(1, 1, 6'd10, 8'h11, 1, 1, 6'd20, 8'h22, !eb, eb, 0, 0, 8'd0);
    end
    cyc(0, 0, 6'd0, 8'd0, 1, 1, 6'd20, 8'h22, 0, 1, 0, 0, 8'd0);

    // Fresh contention after reset, then A drops and B takes over at once.
    do_reset();
    cyc(1, 1, 6'd11, 8'h33, 1, 1, 6'd21, 8'h44, 1, 0, 0, 0, 8'd0);
    cyc(0, 0, 6'd0, 8'd0, 1, 1, 6'd21, 8'h44, 0, 1, 0, 0, 8'd0);

    // B read accepted, then reset drops it; owner state must clear too.
    cyc(0, 0, 6'd0, 8'd0, 1, 0, 6'd20, 8'd0, 0, 1, 0, 0, 8'd0);
    do_reset();
    cyc(1, 1, 6'd12, 8'h55, 1, 1, 6'd22, 8'h66, 1, 0, 0, 0, 8'd0);

    // B write to the top address, then read it back.
    cyc(0, 0, 6'd0, 8'd0, 1, 1, 6'd63, 8'hC3, 0, 1, 0, 0, 8'd0);
    cyc(0, 0, 6'd0, 8'd0, 1, 0, 6'd63, 8'd0, 0, 1, 0, 0, 8'd0);
    idle(0, 1, 8'hC3);

    // A reads its earlier write.
    cyc(1, 0, 6'd10, 8'd0, 0, 0, 6'd0, 8'd0, 1, 0, 0, 0, 8'd0);
    idle(1, 0, 8'h11);

    // Read contention with last=A: round-robin favours B, fixed priority favours A.
    cyc(1, 0, 6'd3, 8'd0, 1, 0, 6'd63, 8'd0, Fixed, !Fixed, 0, 0, 8'd0);
    cyc(!Fixed, 0, 6'd3, 8'd0, Fixed, 0, 6'd63, 8'd0, !Fixed, Fixed, Fixed, !Fixed,
        Fixed ? 8'h5A : 8'hC3);
    idle(!Fixed, Fixed, Fixed ? 8'hC3 : 8'h5A);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
